mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single-port main memory between the multicycle CPU controller's memory access path and a DMA/loader port. Each requester runs a req/ack handshake. The arbiter serialises accesses, drives one memory transaction at a time with a fixed read latency, and returns read data and a one-cycle ack to the granted requester. It sits between the CPU datapath, the DMA engine and the memory block.

## Interface
- AW, 10: word address width.
- DW, 32: data width.
- MEM_LAT, 1: memory read latency in cycles, legal range 1..15. Data is valid MEM_LAT cycles after the mem_en cycle.

- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  AW  CPU word address; stable while cpu_req is high.
- cpu_wdata  in  DW  CPU write data; stable while cpu_req is high.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  last CPU read data; valid from the ack cycle and held until the next CPU read ack.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata: same definitions for the DMA port.
- mem_en  out  1  memory strobe; high exactly one cycle per transaction.
- mem_we  out  1  write enable; high only together with mem_en.
- mem_addr  out  AW  registered address; held from ISSUE through DONE.
- mem_wdata  out  DW  registered write data; held from ISSUE through DONE.
- mem_rdata  in  DW  memory read data.
- grant  out  1  owner of the current or last transaction: 0 = CPU, 1 = DMA.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. The state is 2-bit encoded. A 4-bit latency counter supports WAIT.
- IDLE:
  - If no request is high, stay in IDLE.
  - Otherwise select the owner, latch its we/addr/wdata into the mem_* registers, set grant, and go to ISSUE.
- ISSUE: mem_en = 1, mem_we = latched we. Load the counter with MEM_LAT and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1 and the transaction is a read, capture mem_rdata into the owner's rdata register at that edge.
  - Then go to DONE.
- DONE: assert the owner's ack for one cycle, then return to IDLE.
- Writes use the identical sequence and timing. A write never updates the rdata registers.
- Tie-break when both req are high in IDLE: see Configuration.
- A request is never preempted. A req that rises while busy waits for IDLE.
- Requester duty: deassert req in the cycle after its ack, unless it issues a back-to-back access. A req still high in the IDLE cycle after DONE is treated as a new request.
- The non-owner's ack is always 0.

## Timing
- Reset values (asynchronous): state = IDLE; mem_en, mem_we, cpu_ack, dma_ack = 0; mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0; grant = 0; busy = 0; round-robin pointer = DMA, so the CPU wins the first tie.
- Let req be sampled high in IDLE at the edge ending cycle R. Then:
  - ISSUE (mem_en high) is cycle R+1.
  - WAIT occupies cycles R+2 .. R+1+MEM_LAT.
  - rdata is captured at the edge ending cycle R+1+MEM_LAT.
  - ack is high in cycle R+2+MEM_LAT.
  - IDLE is cycle R+3+MEM_LAT.
- Occupancy per transaction is MEM_LAT+3 cycles. The earliest next mem_en is MEM_LAT+3 cycles after the previous one.
- Reset mid-transaction aborts it. No ack is issued and mem_en falls immediately. The requester re-issues after reset.
- req toggling while busy is ignored. Only the level sampled in IDLE matters.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin tie-break: on a simultaneous request, the port that did not own the last transaction wins.
  - The pointer updates on every grant.
- MEM_ARB_RR_EN undefined:
  - Fixed priority: the CPU always wins ties.
  - The pointer logic is removed. A continuously requesting CPU can starve the DMA port.

## Test plan
- CPU read alone, MEM_LAT=1, addr 0x005, memory holds 0x1234_5678:
  - mem_en in R+1; cpu_ack in R+3.
  - cpu_rdata = 0x1234_5678 in R+3 and after.
  - dma_ack stays 0.
- DMA write of 0xDEAD_BEEF to 0x3FF: mem_en=mem_we=1 for one cycle with mem_addr 0x3FF; dma_ack after 4 cycles; dma_rdata unchanged.
- Both req high together, repeated twice, with MEM_ARB_RR_EN:
  - Grant order is CPU, DMA, CPU, DMA.
  - Without the macro, the order is CPU, CPU, … until the CPU drops req.
- DMA req rising during a CPU transaction: it is served starting in the IDLE cycle after cpu_ack; grant switches to 1 only then.
- rst_n pulled low during WAIT: all outputs are 0 in the same cycle, no ack appears, and the state is IDLE after release.
- MEM_LAT=4, back-to-back CPU reads with req held high: mem_en pulses exactly 7 cycles apart; each ack carries the data of its own address.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the CPU and DMA req/ack ports, the memory strobe/address/data
// and the grant/busy status. The arbiter takes the slave view.
interface mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          grant;
  logic          busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output grant, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  grant, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter serialising accesses to a single-port memory with fixed read latency.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise the CPU always wins ties.
module mem_arbiter #(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          txn_we_q, txn_we_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          dma_ack_q, dma_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;
  logic          grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          pick_dma;

`ifdef MEM_ARB_RR_EN
  logic          rr_last_q, rr_last_d;

  // On a tie the port that did not own the last transaction wins.
  always_comb begin
    if (bus.cpu_req && bus.dma_req) pick_dma = ~rr_last_q;
    else                            pick_dma = bus.dma_req;
  end
`else
  always_comb pick_dma = bus.dma_req & ~bus.cpu_req;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    txn_we_d    = txn_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
`ifdef MEM_ARB_RR_EN
    rr_last_d   = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.dma_req) begin
          state_d     = ISSUE;
          grant_d     = pick_dma;
          txn_we_d    = pick_dma ? bus.dma_we    : bus.cpu_we;
          mem_addr_d  = pick_dma ? bus.dma_addr  : bus.cpu_addr;
          mem_wdata_d = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_dma ? bus.dma_we    : bus.cpu_we;
          busy_d      = 1'b1;
`ifdef MEM_ARB_RR_EN
          rr_last_d   = pick_dma;
`endif
        end
      end
      ISSUE: begin
        cnt_d   = 4'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Memory data is valid in the last WAIT cycle; capture it and ack next cycle.
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          if (!txn_we_q) begin
            if (grant_q) dma_rdata_d = bus.mem_rdata;
            else         cpu_rdata_d = bus.mem_rdata;
          end
          if (grant_q) dma_ack_d = 1'b1;
          else         cpu_ack_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      txn_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      grant_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_last_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      txn_we_q    <= txn_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
`ifdef MEM_ARB_RR_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;

endmodule
